// File: rtl/cassette_player.sv
// cassette_player: streams a .CAS image from SDRAM through a prefetch FIFO and
// plays it out LSB-first as CoCo FSK (0 = one HALF0 cycle, 1 = one HALF1 cycle).
module cassette_player #(
    parameter int ADDR_W     = 25,
    parameter int FIFO_DEPTH = 8,
    parameter int HALF0      = 373,
    parameter int HALF1      = 186,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              en,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              data,
    output logic              playing,
    output logic              eot,
    output logic              underrun,
    output logic [ADDR_W-1:0] position
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] H0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] H1 = CNT_W'(HALF1 - 1);
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t            state;
    logic [7:0]        fifo [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic [ADDR_W-1:0] fetch_addr;
    logic              pending, discard;
    logic [7:0]        shifter, head;
    logic [2:0]        bit_idx;
    logic [CNT_W-1:0]  cnt;
    logic              clear, push, pop, tick, byte_done, last_byte;

    function automatic logic [CNT_W-1:0] half(input logic b);
        return b ? H1 : H0;
    endfunction

    assign clear     = reset | rewind;
    assign tick      = ce & en;
    assign head      = fifo[rd_ptr];
    assign push      = mem_ack & ~discard & ~clear;
    assign byte_done = (state == LOW) & tick & (cnt == '0) & (bit_idx == 3'd7);
    assign last_byte = byte_done & (position + ADDR_W'(1) == tape_len);
    assign pop       = ~clear & en & ~eot & (count != '0) & ((state == IDLE) | (byte_done & ~last_byte));
    assign playing   = en & ~eot & (state != IDLE);

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= mem_data;

    // A request still in flight across reset/rewind stays pending but is marked stale.
    always_ff @(posedge clk) begin
        if (clear) begin
            fetch_addr <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= pending & ~mem_ack;
            discard    <= pending & ~mem_ack;
        end else begin
            mem_rd <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
            if (mem_ack) begin
                pending <= 1'b0;
                discard <= 1'b0;
                if (!discard) fetch_addr <= fetch_addr + ADDR_W'(1);
            end else if (!pending && fetch_addr < tape_len && count < FULL) begin
                mem_rd   <= 1'b1;
                mem_addr <= fetch_addr;
                pending  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            shifter  <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            data     <= 1'b0;
            position <= '0;
            underrun <= 1'b0;
            eot      <= (tape_len == '0);
        end else begin
            case (state)
                IDLE:
                    if (pop) begin
                        state   <= HIGH;
                        data    <= 1'b1;
                        shifter <= head;
                        bit_idx <= '0;
                        cnt     <= half(head[0]);
                    end else if (en && !eot && position < tape_len) begin
                        underrun <= 1'b1;
                    end
                HIGH:
                    if (tick) begin
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                        else begin
                            state <= LOW;
                            data  <= 1'b0;
                            cnt   <= half(shifter[0]);
                        end
                    end
                LOW:
                    if (tick) begin
                        if (cnt != '0) cnt <= cnt - CNT_W'(1);
                        else if (bit_idx != 3'd7) begin
                            state   <= HIGH;
                            data    <= 1'b1;
                            shifter <= shifter >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            cnt     <= half(shifter[1]);
                        end else begin
                            // Chain straight into the next byte when one is waiting.
                            position <= position + ADDR_W'(1);
                            eot      <= eot | last_byte;
                            state    <= pop ? HIGH : IDLE;
                            data     <= pop;
                            shifter  <= head;
                            bit_idx  <= '0;
                            cnt      <= half(head[0]);
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cassette_player.sv
// tb_cassette_player: scoreboard bench; expected FSK half-cycle runs are queued per
// byte and compared against the measured data high/low runs.
module tb_cassette_player;
    localparam int AW = 25;

    logic          clk = 0, reset = 1, ce = 1, en = 0, rewind = 0;
    logic          mem_ack = 0, mem_rd, data, playing, eot, underrun;
    logic [AW-1:0] tape_len = '0, mem_addr, position;
    logic [7:0]    mem_data = 0;

    cassette_player #(.ADDR_W(AW), .FIFO_DEPTH(4), .HALF0(4), .HALF1(2), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .ce(ce), .en(en), .rewind(rewind), .tape_len(tape_len),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
        .data(data), .playing(playing), .eot(eot), .underrun(underrun), .position(position)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Memory model: one request at a time, ack lat cycles after mem_rd.
    logic [7:0]    img [0:15];
    logic [AW-1:0] req_addr = '0;
    int lat = 3, lat_cnt = 0, rd_count = 0, overlap = 0;
    int req_log[$];

    always @(negedge clk) begin
        mem_ack = 0;
        if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0) begin
                mem_ack  = 1;
                mem_data = img[req_addr[3:0]];
            end
        end
        if (reset) begin
            rd_count = 0;
            overlap  = 0;
        end
        if (mem_rd) begin
            if (lat_cnt != 0) overlap++;
            lat_cnt  = lat;
            req_addr = mem_addr;
            rd_count++;
            req_log.push_back(int'(mem_addr));
        end
    end

    // Monitor: measures high/low runs in ce&en ticks and pops the scoreboard per bit.
    int exp_hi[$], exp_lo[$];
    int hi = 0, lo = 0, gaps = 0, ticks = 0, exp_ticks = 0;
    bit started = 0;

    always @(negedge clk) begin
        if (reset || rewind) begin
            hi = 0; lo = 0; gaps = 0; ticks = 0; started = 0;
        end else if (en) begin
            if (lo > 0 && (data || !playing)) begin
                if (exp_hi.size() == 0) check("extra_bit", exp_hi.size(), 1);
                else begin
                    check("hi_run", hi, exp_hi.pop_front());
                    check("lo_run", lo, exp_lo.pop_front());
                end
                hi = 0; lo = 0;
            end
            if (data) begin
                hi++; ticks++; started = 1;
            end else if (playing) begin
                lo++; ticks++;
            end else if (started && !eot) gaps++;
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            int h = b[i] ? 2 : 4;
            exp_hi.push_back(h);
            exp_lo.push_back(h);
            exp_ticks += 2 * h;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int len, input int l);
        @(posedge clk); #1;
        reset = 1; en = 0; rewind = 0; tape_len = AW'(len); lat = l;
        exp_hi.delete(); exp_lo.delete(); req_log.delete(); exp_ticks = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data", data, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_pos", int'(position), 0);
        check("rst_underrun", underrun, 0);
        check("rst_eot", eot, int'(len == 0));
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic wait_eot(input int budget);
        int n = 0;
        while (!eot && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("eot_timeout", eot, 1);
        step(4);
    endtask

    initial begin
        int n;
        // Basic serialisation of 0xA5.
        img[0] = 8'hA5;
        do_reset(1, 3);
        step(20);
        check("t1_rd_count", rd_count, 1);
        push_byte(8'hA5);
        en = 1;
        wait_eot(500);
        check("t1_pos", int'(position), 1);
        check("t1_sb_left", exp_hi.size(), 0);
        check("t1_ticks", ticks, exp_ticks);
        check("t1_underrun", underrun, 0);
        check("t1_data", data, 0);

        // Back-to-back bytes.
        img[0] = 8'h00; img[1] = 8'hFF; img[2] = 8'h01;
        do_reset(3, 3);
        step(30);
        check("t2_prefetch", rd_count, 3);
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'h01);
        en = 1;
        wait_eot(1000);
        step(20);
        check("t2_pos", int'(position), 3);
        check("t2_rd_count", rd_count, 3);
        check("t2_last_addr", req_log.size() > 0 ? req_log[$] : -1, 2);
        check("t2_gaps", gaps, 0);
        check("t2_ticks", ticks, exp_ticks);
        check("t2_sb_left", exp_hi.size(), 0);
        check("t2_underrun", underrun, 0);

        // Pause mid-HIGH with the counter at 1.
        img[0] = 8'h00;
        do_reset(1, 3);
        step(20);
        push_byte(8'h00);
        en = 1;
        n = 0;
        @(negedge clk);
        while (!data && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t3_high_seen", data, 1);
        @(posedge clk);
        @(posedge clk); #1;
        en = 0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (data) n++;
        end
        check("t3_frozen", n, 10);
        @(posedge clk); #1;
        en = 1;
        n = 0;
        @(negedge clk);
        while (data && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("t3_resume_hi", n, 2);
        wait_eot(500);
        check("t3_pos", int'(position), 1);
        check("t3_sb_left", exp_hi.size(), 0);

        // Rewind while a request is outstanding.
        img[0] = 8'h3C; img[1] = 8'h81;
        do_reset(2, 3);
        n = 0;
        @(negedge clk);
        while (!mem_rd && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("t4_rd_seen", mem_rd, 1);
        @(posedge clk); #1;
        rewind = 1;
        step(1);
        @(negedge clk);
        check("t4_rw_pos", int'(position), 0);
        check("t4_rw_rd", mem_rd, 0);
        @(posedge clk); #1;
        rewind = 0;
        step(30);
        check("t4_rd_count", rd_count, 3);
        check("t4_overlap", overlap, 0);
        if (req_log.size() == 3) begin
            check("t4_replay_addr", req_log[1], 0);
            check("t4_second_addr", req_log[2], 1);
        end else check("t4_req_log", req_log.size(), 3);
        push_byte(8'h3C); push_byte(8'h81);
        en = 1;
        wait_eot(1000);
        check("t4_pos", int'(position), 2);
        check("t4_sb_left", exp_hi.size(), 0);

        // Underrun: memory far slower than playback.
        img[0] = 8'h5A; img[1] = 8'h96;
        do_reset(2, 200);
        en = 1;
        step(50);
        @(negedge clk);
        check("t5_underrun", underrun, 1);
        check("t5_idle_data", data, 0);
        check("t5_idle_playing", playing, 0);
        push_byte(8'h5A); push_byte(8'h96);
        wait_eot(3000);
        check("t5_pos", int'(position), 2);
        check("t5_sb_left", exp_hi.size(), 0);
        check("t5_underrun_sticky", underrun, 1);

        // Empty tape.
        do_reset(0, 3);
        en = 1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (data) n++;
        end
        check("t6_data_high", n, 0);
        check("t6_rd_count", rd_count, 0);
        check("t6_eot", eot, 1);
        check("t6_pos", int'(position), 0);
        check("t6_underrun", underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
